draw_scheduler: RTL and testbench

- Command-driven sequencer that shares the VGA plot port among three drawing engines: fillscreen (0), circle (1) and reuleaux (2).
- Accepts draw commands into a small FIFO and dispatches them one at a time using the engines' level start/done handshake.
- Muxes the active engine's plot outputs onto the single VGA port.
- Sits between the top-level command source and the engines/VGA adapter.

---
 rtl/draw_scheduler.sv | 166 ++++++++++++++++
 tb/tb_draw_scheduler.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_scheduler.sv
// Command sequencer for the shared VGA plot port. Commands are queued in a small FIFO and
// run one at a time on the fillscreen, circle or reuleaux engine; the active engine's plot is muxed out.
module draw_scheduler #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 32768
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_type,
  input  logic [2:0]  cmd_colour,
  input  logic [7:0]  cmd_x,
  input  logic [6:0]  cmd_y,
  input  logic [7:0]  cmd_size,
  output logic [2:0]  eng_start,
  input  logic [2:0]  eng_done,
  output logic [2:0]  eng_colour,
  output logic [7:0]  eng_centre_x,
  output logic [6:0]  eng_centre_y,
  output logic [7:0]  eng_size,
  input  logic [23:0] eng_vga_x,
  input  logic [20:0] eng_vga_y,
  input  logic [8:0]  eng_vga_colour,
  input  logic [2:0]  eng_vga_plot,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [2:0]  vga_colour,
  output logic        vga_plot,
  output logic        busy,
  output logic [7:0]  cmds_done,
  output logic        err_cmd,
  output logic        err_timeout
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned WdW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);
  localparam logic [WdW-1:0]  WdLast  = WdW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StRun, StRelease} state_e;

  typedef struct packed {
    logic [1:0] kind;
    logic [2:0] colour;
    logic [7:0] x;
    logic [6:0] y;
    logic [7:0] size;
  } cmd_t;

  cmd_t            fifo_mem [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  state_e          state_q;
  logic [2:0]      sel_oh_q;
  logic [WdW-1:0]  wdog_q;
  logic            accept, push, pop, sel_done;
  cmd_t            head;

  assign cmd_ready = (count_q != CntFull);
  assign accept    = cmd_valid & cmd_ready;
  // Illegal commands complete the handshake but never reach the queue.
  assign push      = accept & (cmd_type != 2'd3);
  assign pop       = (state_q == StIdle) & (count_q != '0);
  assign head      = fifo_mem[rd_ptr_q];
  assign sel_done  = |(eng_done & sel_oh_q);
  assign busy      = (state_q != StIdle) | (count_q != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= '{kind: cmd_type, colour: cmd_colour, x: cmd_x, y: cmd_y,
                              size: cmd_size};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      sel_oh_q     <= '0;
      eng_start    <= '0;
      eng_colour   <= '0;
      eng_centre_x <= '0;
      eng_centre_y <= '0;
      eng_size     <= '0;
      wdog_q       <= '0;
      cmds_done    <= '0;
      err_cmd      <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      if (accept && cmd_type == 2'd3) err_cmd <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            state_q      <= StRun;
            sel_oh_q     <= 3'b001 << head.kind;
            eng_start    <= 3'b001 << head.kind;
            eng_colour   <= head.colour;
            eng_centre_x <= head.x;
            eng_centre_y <= head.y;
            eng_size     <= head.size;
            wdog_q       <= '0;
          end
        end
        StRun: begin
          if (sel_done) begin
            state_q   <= StRelease;
            eng_start <= '0;
            cmds_done <= cmds_done + 8'd1;
          end else if (wdog_q == WdLast) begin
            state_q     <= StRelease;
            eng_start   <= '0;
            err_timeout <= 1'b1;
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
        end
        StRelease: begin
          if (!sel_done) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    vga_x      = '0;
    vga_y      = '0;
    vga_colour = '0;
    if (state_q == StRun) begin
      unique case (sel_oh_q)
        3'b001: begin
          vga_x      = eng_vga_x[7:0];
          vga_y      = eng_vga_y[6:0];
          vga_colour = eng_vga_colour[2:0];
        end
        3'b010: begin
          vga_x      = eng_vga_x[15:8];
          vga_y      = eng_vga_y[13:7];
          vga_colour = eng_vga_colour[5:3];
        end
        3'b100: begin
          vga_x      = eng_vga_x[23:16];
          vga_y      = eng_vga_y[20:14];
          vga_colour = eng_vga_colour[8:6];
        end
        default: ;
      endcase
    end
  end

  assign vga_plot = (|(eng_vga_plot & sel_oh_q)) & (state_q == StRun);

endmodule

// File: tb/tb_draw_scheduler.sv
// Directed bench for draw_scheduler: accepted commands go into a scoreboard queue and are
// checked against the engine interface when each dispatch appears.
module tb_draw_scheduler;

  typedef struct {
    logic [1:0] t;
    logic [2:0] c;
    logic [7:0] x;
    logic [6:0] y;
    logic [7:0] s;
  } cmd_t;

  logic        clk, rst_n;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_type;
  logic [2:0]  cmd_colour;
  logic [7:0]  cmd_x;
  logic [6:0]  cmd_y;
  logic [7:0]  cmd_size;
  logic [2:0]  eng_start, eng_done, eng_colour;
  logic [7:0]  eng_centre_x, eng_size;
  logic [6:0]  eng_centre_y;
  logic [23:0] eng_vga_x;
  logic [20:0] eng_vga_y;
  logic [8:0]  eng_vga_colour;
  logic [2:0]  eng_vga_plot;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot, busy, err_cmd, err_timeout;
  logic [7:0]  cmds_done;

  int   checks = 0;
  int   errors = 0;
  cmd_t sb[$];

  draw_scheduler #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_colour(cmd_colour), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_size(cmd_size),
    .eng_start(eng_start), .eng_done(eng_done), .eng_colour(eng_colour),
    .eng_centre_x(eng_centre_x), .eng_centre_y(eng_centre_y), .eng_size(eng_size),
    .eng_vga_x(eng_vga_x), .eng_vga_y(eng_vga_y), .eng_vga_colour(eng_vga_colour),
    .eng_vga_plot(eng_vga_plot),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
    .busy(busy), .cmds_done(cmds_done), .err_cmd(err_cmd), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold the current command until the handshake edge; legal ones go to the scoreboard.
  task automatic wait_accept();
    logic acc;
    for (int n = 0; n < 200; n++) begin
      acc = cmd_ready;
      tick();
      if (acc) begin
        if (cmd_type != 2'd3) sb.push_back('{cmd_type, cmd_colour, cmd_x, cmd_y, cmd_size});
        return;
      end
    end
    chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic offer(input logic [1:0] t, input logic [2:0] c, input logic [7:0] x,
                       input logic [6:0] y, input logic [7:0] s);
    cmd_valid  = 1'b1;
    cmd_type   = t;
    cmd_colour = c;
    cmd_x      = x;
    cmd_y      = y;
    cmd_size   = s;
  endtask

  task automatic send(input logic [1:0] t, input logic [2:0] c, input logic [7:0] x,
                      input logic [6:0] y, input logic [7:0] s);
    offer(t, c, x, y, s);
    wait_accept();
    cmd_valid = 1'b0;
  endtask

  task automatic expect_dispatch();
    cmd_t e;
    int   n;
    n = 0;
    while (eng_start == 3'b000 && n < 60) begin
      tick();
      n++;
    end
    chk("dispatch_seen", {31'd0, eng_start != 3'b000}, 32'd1);
    if (sb.size() == 0) begin
      chk("sb_nonempty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    chk("eng_start", {29'd0, eng_start}, {29'd0, 3'b001 << e.t});
    chk("eng_colour", {29'd0, eng_colour}, {29'd0, e.c});
    chk("eng_centre_x", {24'd0, eng_centre_x}, {24'd0, e.x});
    chk("eng_centre_y", {25'd0, eng_centre_y}, {25'd0, e.y});
    chk("eng_size", {24'd0, eng_size}, {24'd0, e.s});
  endtask

  task automatic finish_engine(input int k);
    eng_done = 3'b001 << k;
    tick();
    chk("start_drop", {29'd0, eng_start}, 32'd0);
    eng_done = 3'b000;
    tick();
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_type = '0; cmd_colour = '0; cmd_x = '0; cmd_y = '0; cmd_size = '0;
    eng_done = '0; eng_vga_x = '0; eng_vga_y = '0; eng_vga_colour = '0; eng_vga_plot = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_start", {29'd0, eng_start}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done_cnt", {24'd0, cmds_done}, 32'd0);
    chk("rst_errs", {30'd0, err_cmd, err_timeout}, 32'd0);
    chk("rst_plot", {31'd0, vga_plot}, 32'd0);

    // Single reuleaux.
    send(2'd2, 3'd2, 8'd40, 7'd80, 8'd3);
    chk("start_after_e0", {29'd0, eng_start}, 32'd0);
    tick();
    chk("start_after_e1", {29'd0, eng_start}, 32'b100);
    expect_dispatch();
    eng_vga_x = {8'd99, 8'd10, 8'd7};
    eng_vga_y = {7'd60, 7'd5, 7'd3};
    eng_vga_colour = {3'd6, 3'd1, 3'd4};
    eng_vga_plot = 3'b011;
    #1;
    chk("plot_other_eng", {31'd0, vga_plot}, 32'd0);
    chk("vga_x_sel", {24'd0, vga_x}, {24'd0, eng_vga_x[23:16]});
    chk("vga_y_sel", {25'd0, vga_y}, {25'd0, eng_vga_y[20:14]});
    chk("vga_col_sel", {29'd0, vga_colour}, {29'd0, eng_vga_colour[8:6]});
    eng_vga_plot = 3'b100;
    #1;
    chk("plot_sel_eng", {31'd0, vga_plot}, 32'd1);
    eng_done = 3'b011;
    tick();
    chk("other_done_ignored", {29'd0, eng_start}, 32'b100);
    chk("other_done_cnt", {24'd0, cmds_done}, 32'd0);
    eng_done = 3'b100;
    tick();
    chk("done_start_drop", {29'd0, eng_start}, 32'd0);
    chk("done_cnt1", {24'd0, cmds_done}, 32'd1);
    chk("release_busy", {31'd0, busy}, 32'd1);
    chk("release_plot", {31'd0, vga_plot}, 32'd0);
    chk("release_vga_x", {24'd0, vga_x}, 32'd0);
    tick();
    eng_done = 3'b000;
    tick();
    chk("idle_busy", {31'd0, busy}, 32'd0);
    eng_vga_plot = 3'b000;

    // Illegal command.
    send(2'd3, 3'd7, 8'd1, 7'd1, 8'd1);
    chk("illegal_err", {31'd0, err_cmd}, 32'd1);
    chk("illegal_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("illegal_start", {29'd0, eng_start}, 32'd0);
    chk("illegal_cnt", {24'd0, cmds_done}, 32'd1);

    // Fill the FIFO behind a running circle.
    send(2'd1, 3'd1, 8'd11, 7'd12, 8'd13);
    send(2'd0, 3'd2, 8'd21, 7'd22, 8'd23);
    send(2'd2, 3'd3, 8'd31, 7'd32, 8'd33);
    send(2'd1, 3'd4, 8'd41, 7'd42, 8'd43);
    send(2'd0, 3'd5, 8'd51, 7'd52, 8'd53);
    chk("full_ready", {31'd0, cmd_ready}, 32'd0);
    offer(2'd2, 3'd6, 8'd61, 7'd62, 8'd63);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("sixth_held", {31'd0, cmd_ready}, 32'd0);
    end
    expect_dispatch();
    eng_done = 3'b010;
    tick();
    chk("circle_done_drop", {29'd0, eng_start}, 32'd0);
    chk("done_cnt2", {24'd0, cmds_done}, 32'd2);
    eng_done = 3'b000;
    wait_accept();
    cmd_valid = 1'b0;
    expect_dispatch();
    chk("refull_ready", {31'd0, cmd_ready}, 32'd0);
    finish_engine(0);

    // Reuleaux that never finishes: watchdog abort.
    expect_dispatch();
    n = 1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (eng_start == 3'b000) break;
      n++;
    end
    chk("timeout_run_cycles", n, 32'd16);
    chk("timeout_err", {31'd0, err_timeout}, 32'd1);
    chk("timeout_cnt", {24'd0, cmds_done}, 32'd3);
    expect_dispatch();
    finish_engine(1);
    expect_dispatch();
    finish_engine(0);
    expect_dispatch();
    finish_engine(2);
    chk("final_cnt", {24'd0, cmds_done}, 32'd6);
    chk("final_busy", {31'd0, busy}, 32'd0);
    chk("sb_drained", sb.size(), 32'd0);

    // Asynchronous reset in the middle of a circle with a command still queued.
    send(2'd1, 3'd3, 8'd70, 7'd71, 8'd72);
    expect_dispatch();
    send(2'd0, 3'd1, 8'd5, 7'd6, 8'd7);
    eng_vga_plot = 3'b010;
    #1;
    chk("pre_rst_plot", {31'd0, vga_plot}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_start", {29'd0, eng_start}, 32'd0);
    chk("async_plot", {31'd0, vga_plot}, 32'd0);
    chk("async_busy", {31'd0, busy}, 32'd0);
    chk("async_cnt", {24'd0, cmds_done}, 32'd0);
    chk("async_errs", {30'd0, err_cmd, err_timeout}, 32'd0);
    sb.delete();
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("post_rst_start", {29'd0, eng_start}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
